// File: rtl/filter_window_controller_if.sv
// Raster pixel stream into the 3x3 window controller: valid/ready handshake,
// one 12-bit RGB444 pixel per transfer.
interface filter_window_controller_if;
  logic [11:0] pix_in;
  logic        pix_valid;
  logic        pix_ready;

  modport master (output pix_in, output pix_valid, input pix_ready);
  modport slave  (input pix_in, input pix_valid, output pix_ready);
endinterface

// File: rtl/filter_window_controller.sv
// Builds edge-clamped 3x3 RGB444 neighbourhoods from a raster pixel stream and tags the
// free-running filter's output with valid and coordinates once the filter latency has elapsed.
module filter_window_controller #(
  parameter int IMG_W          = 640,
  parameter int IMG_H          = 480,
  parameter int FILTER_LATENCY = 4,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  filter_window_controller_if.slave pix_if,
  output logic [107:0]              color_data,
  output logic                      win_valid,
  input  logic [11:0]               filt_in,
  output logic [11:0]               out_pix,
  output logic                      out_valid,
  output logic [XW-1:0]             out_x,
  output logic [YW-1:0]             out_y,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int YIW = $clog2(IMG_H + 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [XW-1:0]  X_ZERO = '0;
  localparam logic [XW-1:0]  X_ONE  = XW'(1);
  localparam logic [XW-1:0]  X_LAST = XW'(IMG_W - 1);
  localparam logic [YIW-1:0] Y_ONE  = YIW'(1);
  localparam logic [YIW-1:0] Y_LAST = YIW'(IMG_H - 1);
  localparam logic [YIW-1:0] Y_END  = YIW'(IMG_H + 1);

  logic [2:0]     state_q, state_d;
  logic [XW-1:0]  sx_q, sx_d;
  logic [YIW-1:0] sy_q, sy_d;
  logic [35:0]    col_a_q, col_a_d;
  logic [35:0]    col_b_q, col_b_d;
  logic [107:0]   color_q, color_d;
  logic           win_valid_q, win_valid_d;
  logic [XW-1:0]  win_x_q, win_x_d;
  logic [YW-1:0]  win_y_q, win_y_d;

  logic [FILTER_LATENCY-1:0]         dl_valid_q, dl_valid_d;
  logic [FILTER_LATENCY-1:0][XW-1:0] dl_x_q, dl_x_d;
  logic [FILTER_LATENCY-1:0][YW-1:0] dl_y_q, dl_y_d;

  logic [11:0] line0_mem [IMG_W];
  logic [11:0] line1_mem [IMG_W];

  logic        run_xfer, step, emit;
  logic [11:0] rd0, rd1, new_up, new_down;
  logic [35:0] col_n, win_l, win_c, win_r;

  // line0 holds the previous stream row, line1 the one before; read old data, then overwrite
  always_ff @(posedge clk) begin
    if (run_xfer) begin
      line1_mem[sx_q] <= rd0;
      line0_mem[sx_q] <= pix_if.pix_in;
    end
  end

  always_comb begin
    run_xfer = (state_q == S_RUN) && pix_if.pix_valid;
    step     = run_xfer || (state_q == S_FLUSH);
    emit     = (sy_q > Y_ONE) || ((sy_q == Y_ONE) && (sx_q != X_ZERO));
    rd0      = line0_mem[sx_q];
    rd1      = line1_mem[sx_q];
    new_up   = (sy_q == Y_ONE) ? rd0 : rd1;
    new_down = (state_q == S_FLUSH) ? rd0 : pix_if.pix_in;
    col_n    = {new_up, rd0, new_down};

    // Column x=0 of a stream row closes the previous row's last window; x=1 opens a row
    win_l = col_a_q;
    win_c = col_b_q;
    win_r = col_n;
    if (sx_q == X_ZERO) begin
      win_r = col_b_q;
    end else if (sx_q == X_ONE) begin
      win_l = col_b_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    col_a_d     = col_a_q;
    col_b_d     = col_b_q;
    color_d     = color_q;
    win_valid_d = 1'b0;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;

    if (step) begin
      col_a_d = col_b_q;
      col_b_d = col_n;
      if (sx_q == X_LAST) begin
        sx_d = X_ZERO;
        sy_d = sy_q + Y_ONE;
      end else begin
        sx_d = sx_q + X_ONE;
      end
      if (emit) begin
        win_valid_d = 1'b1;
        color_d = {win_c[23:12], win_l[23:12], win_r[23:12],
                   win_c[35:24], win_c[11:0],
                   win_l[35:24], win_r[35:24],
                   win_l[11:0],  win_r[11:0]};
        win_x_d = (sx_q == X_ZERO) ? X_LAST : sx_q - X_ONE;
        win_y_d = YW'(sy_q - ((sx_q == X_ZERO) ? YIW'(2) : Y_ONE));
      end
    end

    dl_valid_d[0] = win_valid_q;
    dl_x_d[0]     = win_x_q;
    dl_y_d[0]     = win_y_q;
    for (int i = 1; i < FILTER_LATENCY; i++) begin
      dl_valid_d[i] = dl_valid_q[i-1];
      dl_x_d[i]     = dl_x_q[i-1];
      dl_y_d[i]     = dl_y_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          sx_d    = X_ZERO;
          sy_d    = '0;
        end
      end
      S_RUN: begin
        if (run_xfer && (sx_q == X_LAST) && (sy_q == Y_LAST)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if ((sx_q == X_ZERO) && (sy_q == Y_END)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (dl_valid_d == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sx_q        <= '0;
      sy_q        <= '0;
      col_a_q     <= '0;
      col_b_q     <= '0;
      color_q     <= '0;
      win_valid_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      dl_valid_q  <= '0;
      dl_x_q      <= '0;
      dl_y_q      <= '0;
    end else begin
      state_q     <= state_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      col_a_q     <= col_a_d;
      col_b_q     <= col_b_d;
      color_q     <= color_d;
      win_valid_q <= win_valid_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      dl_valid_q  <= dl_valid_d;
      dl_x_q      <= dl_x_d;
      dl_y_q      <= dl_y_d;
    end
  end

  assign pix_if.pix_ready = (state_q == S_RUN);
  assign busy             = (state_q != S_IDLE);
  assign frame_done       = (state_q == S_DONE);
  assign color_data       = color_q;
  assign win_valid        = win_valid_q;
  assign out_valid        = dl_valid_q[FILTER_LATENCY-1];
  assign out_x            = dl_x_q[FILTER_LATENCY-1];
  assign out_y            = dl_y_q[FILTER_LATENCY-1];
  assign out_pix          = out_valid ? filt_in : 12'd0;

endmodule

// File: tb/tb_filter_window_controller.sv
// Directed bench for filter_window_controller on a 4x3 frame with a 4-cycle model filter
// that returns the window centre; expected windows come from a clamp-based neighbour model.
module tb_filter_window_controller;
  localparam int W = 4;
  localparam int H = 3;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [107:0] color_data;
  logic         win_valid;
  logic [11:0]  filt_in;
  logic [11:0]  out_pix;
  logic         out_valid;
  logic [1:0]   out_x;
  logic [1:0]   out_y;
  logic         busy;
  logic         frame_done;

  filter_window_controller_if pif ();

  filter_window_controller #(.IMG_W(W), .IMG_H(H), .FILTER_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_if(pif),
    .color_data(color_data), .win_valid(win_valid), .filt_in(filt_in),
    .out_pix(out_pix), .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [11:0] filt_pipe [L] = '{default: 12'd0};
  always @(posedge clk) begin
    filt_pipe[0] <= color_data[107:96];
    for (int i = 1; i < L; i++) filt_pipe[i] <= filt_pipe[i-1];
  end
  assign filt_in = filt_pipe[L-1];

  int n_checks = 0;
  int n_pass = 0;
  int cycle = 0;
  logic [107:0] win_q [$];
  logic [15:0]  out_q [$];
  int win_cyc [$];
  int xfer_cyc [$];
  int done_cnt = 0;
  int done_cyc = 0;
  int last_out_cyc = 0;
  int stall_win = 0;
  bit stall_prev = 1'b0;

  always @(negedge clk) begin
    cycle++;
    if (win_valid) begin
      win_q.push_back(color_data);
      win_cyc.push_back(cycle);
      if (stall_prev) stall_win++;
    end
    if (out_valid) begin
      out_q.push_back({out_pix, out_x, out_y});
      last_out_cyc = cycle;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cycle;
    end
    if (pif.pix_valid && pif.pix_ready) xfer_cyc.push_back(cycle);
    stall_prev = pif.pix_ready && !pif.pix_valid;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [11:0] pv(input int x, input int y);
    return 12'(y * W + x);
  endfunction

  function automatic logic [107:0] win_exp(input int cx, input int cy);
    int xl, xr, yu, yd;
    xl = (cx == 0) ? 0 : cx - 1;
    xr = (cx == W - 1) ? W - 1 : cx + 1;
    yu = (cy == 0) ? 0 : cy - 1;
    yd = (cy == H - 1) ? H - 1 : cy + 1;
    return {pv(cx, cy), pv(xl, cy), pv(xr, cy), pv(cx, yu), pv(cx, yd),
            pv(xl, yu), pv(xr, yu), pv(xl, yd), pv(xr, yd)};
  endfunction

  localparam logic [107:0] FIRST_WIN = {12'd0, 12'd0, 12'd1, 12'd0, 12'd4, 12'd0, 12'd1, 12'd4, 12'd5};
  localparam logic [107:0] LAST_WIN  = {12'd11, 12'd10, 12'd11, 12'd7, 12'd11, 12'd6, 12'd7, 12'd10, 12'd11};

  task automatic clear_mon();
    win_q.delete();
    out_q.delete();
    win_cyc.delete();
    xfer_cyc.delete();
    done_cnt = 0;
    done_cyc = 0;
    last_out_cyc = 0;
    stall_win = 0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pixels(input int n, input bit gaps, input int start_at);
    int guard;
    bit rdy;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
          pif.pix_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      pif.pix_in    = 12'(i);
      pif.pix_valid = 1'b1;
      start         = (i == start_at);
      guard = 0;
      do begin
        rdy = pif.pix_ready;
        @(posedge clk); #1;
        start = 1'b0;
        guard++;
      end while (!rdy && guard < 50);
      if (!rdy) begin
        n_checks++;
        $display("[TB] FAIL handshake_timeout: pixel %0d got no pix_ready, expected acceptance", i);
      end
    end
    pif.pix_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (done_cnt == 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (done_cnt == 0) $display("[TB] FAIL frame_done_timeout: got no pulse, expected one within 300 cycles");
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (color_data !== 108'd0) $display("[TB] FAIL reset_color_data: got %h, expected 0", color_data);
    else n_pass++;
    n_checks++;
    if ({win_valid, out_valid, busy, frame_done, pif.pix_ready} !== 5'b0)
      $display("[TB] FAIL reset_flags: got %b, expected 00000", {win_valid, out_valid, busy, frame_done, pif.pix_ready});
    else n_pass++;
    n_checks++;
    if ({out_pix, out_x, out_y} !== 16'd0) $display("[TB] FAIL reset_out_bus: got %h, expected 0", {out_pix, out_x, out_y});
    else n_pass++;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, pif.pix_ready} !== 2'b00) $display("[TB] FAIL idle_after_reset: got %b, expected 00", {busy, pif.pix_ready});
    else n_pass++;
  endtask

  task automatic test_basic_frame();
    int bad, first_bad;
    clear_mon();
    start_frame();
    send_pixels(W * H, 1'b0, -1);
    bad = 0;
    for (int c = 0; c < W + 1; c++) begin
      @(negedge clk);
      if (pif.pix_ready) bad++;
    end
    n_checks++;
    if (bad != 0) $display("[TB] FAIL flush_ready_low: got %0d ready cycles, expected 0", bad);
    else n_pass++;
    wait_done();

    n_checks++;
    if (win_q.size() != W * H) $display("[TB] FAIL win_count: got %0d, expected %0d", win_q.size(), W * H);
    else n_pass++;
    n_checks++;
    if (win_q.size() == 0 || xfer_cyc.size() < 6 || win_cyc[0] != xfer_cyc[5] + 1)
      $display("[TB] FAIL first_win_timing: got cycle %0d, expected %0d", (win_cyc.size() > 0) ? win_cyc[0] : -1,
               (xfer_cyc.size() > 5) ? xfer_cyc[5] + 1 : -1);
    else n_pass++;
    n_checks++;
    if (win_q.size() == 0 || win_q[0] !== FIRST_WIN)
      $display("[TB] FAIL first_window: got %h, expected %h", (win_q.size() > 0) ? win_q[0] : 108'd0, FIRST_WIN);
    else n_pass++;
    n_checks++;
    if (win_q.size() != W * H || win_q[W*H-1] !== LAST_WIN)
      $display("[TB] FAIL last_window: got %h, expected %h", (win_q.size() > 0) ? win_q[win_q.size()-1] : 108'd0, LAST_WIN);
    else n_pass++;

    first_bad = -1;
    for (int k = 0; k < win_q.size() && k < W * H; k++)
      if (first_bad < 0 && win_q[k] !== win_exp(k % W, k / W)) first_bad = k;
    n_checks++;
    if (first_bad >= 0) $display("[TB] FAIL window_sequence: index %0d got %h, expected %h", first_bad, win_q[first_bad], win_exp(first_bad % W, first_bad / W));
    else n_pass++;

    n_checks++;
    if (out_q.size() != W * H) $display("[TB] FAIL out_count: got %0d, expected %0d", out_q.size(), W * H);
    else n_pass++;
    first_bad = -1;
    for (int k = 0; k < out_q.size() && k < W * H; k++)
      if (first_bad < 0 && out_q[k] !== {12'(k), 2'(k % W), 2'(k / W)}) first_bad = k;
    n_checks++;
    if (first_bad >= 0) $display("[TB] FAIL out_sequence: index %0d got %h, expected %h", first_bad, out_q[first_bad], {12'(first_bad), 2'(first_bad % W), 2'(first_bad / W)});
    else n_pass++;

    n_checks++;
    if (done_cnt != 1) $display("[TB] FAIL frame_done_count: got %0d, expected 1", done_cnt);
    else n_pass++;
    n_checks++;
    if (done_cyc <= last_out_cyc) $display("[TB] FAIL frame_done_order: got cycle %0d, expected after %0d", done_cyc, last_out_cyc);
    else n_pass++;
  endtask

  task automatic test_stall_gaps();
    int first_bad;
    clear_mon();
    start_frame();
    send_pixels(W * H, 1'b1, -1);
    wait_done();
    n_checks++;
    if (stall_win != 0) $display("[TB] FAIL stall_no_window: got %0d windows after stalls, expected 0", stall_win);
    else n_pass++;
    n_checks++;
    if (win_q.size() != W * H || out_q.size() != W * H)
      $display("[TB] FAIL gap_counts: got %0d windows %0d outputs, expected %0d each", win_q.size(), out_q.size(), W * H);
    else n_pass++;
    first_bad = -1;
    for (int k = 0; k < win_q.size() && k < W * H; k++)
      if (first_bad < 0 && win_q[k] !== win_exp(k % W, k / W)) first_bad = k;
    n_checks++;
    if (first_bad >= 0) $display("[TB] FAIL gap_window_sequence: index %0d got %h, expected %h", first_bad, win_q[first_bad], win_exp(first_bad % W, first_bad / W));
    else n_pass++;
    first_bad = -1;
    for (int k = 0; k < out_q.size() && k < W * H; k++)
      if (first_bad < 0 && out_q[k] !== {12'(k), 2'(k % W), 2'(k / W)}) first_bad = k;
    n_checks++;
    if (first_bad >= 0) $display("[TB] FAIL gap_out_sequence: index %0d got %h, expected %h", first_bad, out_q[first_bad], {12'(first_bad), 2'(first_bad % W), 2'(first_bad / W)});
    else n_pass++;
  endtask

  task automatic test_idle_and_start();
    int ready_seen, busy_seen, first_bad;
    clear_mon();
    pif.pix_in = 12'hABC;
    pif.pix_valid = 1'b1;
    ready_seen = 0;
    busy_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (pif.pix_ready) ready_seen++;
      if (busy) busy_seen++;
    end
    n_checks++;
    if (ready_seen != 0 || busy_seen != 0 || win_q.size() != 0)
      $display("[TB] FAIL idle_ignores_valid: got ready %0d busy %0d windows %0d, expected 0 0 0", ready_seen, busy_seen, win_q.size());
    else n_pass++;
    @(posedge clk); #1;
    start_frame();
    send_pixels(W * H, 1'b0, 6);
    wait_done();
    n_checks++;
    if (win_q.size() != W * H || done_cnt != 1)
      $display("[TB] FAIL start_in_run: got %0d windows %0d done, expected %0d and 1", win_q.size(), done_cnt, W * H);
    else n_pass++;
    first_bad = -1;
    for (int k = 0; k < win_q.size() && k < W * H; k++)
      if (first_bad < 0 && win_q[k] !== win_exp(k % W, k / W)) first_bad = k;
    n_checks++;
    if (first_bad >= 0) $display("[TB] FAIL start_in_run_sequence: index %0d got %h, expected %h", first_bad, win_q[first_bad], win_exp(first_bad % W, first_bad / W));
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int first_bad;
    clear_mon();
    start_frame();
    send_pixels(8, 1'b0, -1);
    reset = 1'b0;
    #1;
    n_checks++;
    if (color_data !== 108'd0) $display("[TB] FAIL midreset_color_data: got %h, expected 0", color_data);
    else n_pass++;
    n_checks++;
    if ({win_valid, out_valid, busy, frame_done, pif.pix_ready, out_pix, out_x, out_y} !== 21'd0)
      $display("[TB] FAIL midreset_outputs: got %h, expected 0", {win_valid, out_valid, busy, frame_done, pif.pix_ready, out_pix, out_x, out_y});
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    start_frame();
    send_pixels(W * H, 1'b0, -1);
    wait_done();
    n_checks++;
    if (win_q.size() != W * H || win_q[0] !== FIRST_WIN || win_q[W*H-1] !== LAST_WIN)
      $display("[TB] FAIL restart_windows: got %0d windows first %h, expected %0d first %h",
               win_q.size(), (win_q.size() > 0) ? win_q[0] : 108'd0, W * H, FIRST_WIN);
    else n_pass++;
    first_bad = -1;
    for (int k = 0; k < out_q.size() && k < W * H; k++)
      if (first_bad < 0 && out_q[k] !== {12'(k), 2'(k % W), 2'(k / W)}) first_bad = k;
    n_checks++;
    if (first_bad >= 0 || out_q.size() != W * H)
      $display("[TB] FAIL restart_outputs: got %0d outputs first bad %0d, expected %0d and none", out_q.size(), first_bad, W * H);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    pif.pix_valid = 1'b0;
    pif.pix_in = 12'd0;
    test_reset();
    test_basic_frame();
    test_stall_gaps();
    test_idle_and_start();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
